// File: rtl/t5_pkg.sv
// rtl/t5_pkg.sv - shared constants and helpers for the t5 instruction memory
package t5_pkg;

  localparam int          T5_IWB_AW  = 30;
  localparam logic [31:0] T5_NOP     = 32'h00000013;
  localparam int          T5_SEL_W   = 4;
  localparam int          T5_LAT_MIN = 1;
  localparam int          T5_LAT_MAX = 4;

  // True when a word address lies beyond a 2**aw word array.
  function automatic logic t5_out_of_range(input logic [T5_IWB_AW-1:0] adr, input int aw);
    return (adr >> aw) != '0;
  endfunction

endpackage

// File: rtl/t5_imem_if.sv
// rtl/t5_imem_if.sv - fetch (iwb) and load (lwb) bus bundle for t5_imem
interface t5_imem_if;
  import t5_pkg::*;

  logic [T5_IWB_AW-1:0] iwb_adr;
  logic                 iwb_stb;
  logic                 iwb_wre;
  logic [T5_SEL_W-1:0]  iwb_sel;
  logic [31:0]          iwb_dat;
  logic                 iwb_ack;
  logic                 iwb_err;
  logic [T5_IWB_AW-1:0] lwb_adr;
  logic [31:0]          lwb_dat_i;
  logic [T5_SEL_W-1:0]  lwb_sel;
  logic                 lwb_stb;
  logic                 lwb_wre;
  logic [31:0]          lwb_dat_o;
  logic                 lwb_ack;

  modport master (
    output iwb_adr, iwb_stb, iwb_wre, iwb_sel, lwb_adr, lwb_dat_i, lwb_sel, lwb_stb, lwb_wre,
    input  iwb_dat, iwb_ack, iwb_err, lwb_dat_o, lwb_ack
  );

  modport slave (
    input  iwb_adr, iwb_stb, iwb_wre, iwb_sel, lwb_adr, lwb_dat_i, lwb_sel, lwb_stb, lwb_wre,
    output iwb_dat, iwb_ack, iwb_err, lwb_dat_o, lwb_ack
  );

endinterface

// File: rtl/t5_imem_ram.sv
// rtl/t5_imem_ram.sv - true dual-port byte-enable RAM; parity columns when T5_IMEM_PARITY_EN
module t5_imem_ram
  import t5_pkg::*;
#(
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic                sclk,
  input  logic                srst,
  input  logic                a_re_i,
  input  logic [AW-1:0]       a_addr_i,
  output logic [31:0]         a_rdata_o,
  output logic                a_perr_o,
  input  logic                b_en_i,
  input  logic                b_we_i,
  input  logic [T5_SEL_W-1:0] b_sel_i,
  input  logic [AW-1:0]       b_addr_i,
  input  logic [31:0]         b_wdata_i,
  output logic [31:0]         b_rdata_o
);

`ifdef T5_IMEM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam int W     = LW * T5_SEL_W;
  localparam int DEPTH = 2 ** AW;

  // Each byte lane is {parity, byte} when parity is stored, else just the byte.
  function automatic logic [W-1:0] pack(input logic [31:0] d);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < T5_SEL_W; i++) begin
      w[i*LW +: 8] = d[i*8 +: 8];
`ifdef T5_IMEM_PARITY_EN
      w[i*LW + 8] = ^d[i*8 +: 8];
`endif
    end
    return w;
  endfunction

  function automatic logic [31:0] unpack(input logic [W-1:0] w);
    logic [31:0] d;
    for (int i = 0; i < T5_SEL_W; i++) d[i*8 +: 8] = w[i*LW +: 8];
    return d;
  endfunction

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  a_q, b_q, wr_w;

  // Every word starts as NOP.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = pack(T5_NOP);
  end

  assign wr_w = pack(b_wdata_i);

  always_ff @(posedge sclk) begin
    if (b_en_i && b_we_i) begin
      for (int i = 0; i < T5_SEL_W; i++) begin
        if (b_sel_i[i]) mem[b_addr_i][i*LW +: LW] <= wr_w[i*LW +: LW];
      end
    end
  end

  // Reads sample the array before this cycle's write lands (read-before-write).
  always_ff @(posedge sclk) begin
    if (srst)        a_q <= '0;
    else if (a_re_i) a_q <= mem[a_addr_i];
  end

  always_ff @(posedge sclk) begin
    if (srst)        b_q <= '0;
    else if (b_en_i) b_q <= mem[b_addr_i];
  end

  assign a_rdata_o = unpack(a_q);
  assign b_rdata_o = unpack(b_q);

`ifdef T5_IMEM_PARITY_EN
  always_comb begin
    a_perr_o = 1'b0;
    for (int i = 0; i < T5_SEL_W; i++) a_perr_o = a_perr_o | (^a_q[i*LW +: LW]);
  end
`else
  assign a_perr_o = 1'b0;
`endif

endmodule

// File: rtl/t5_imem.sv
// rtl/t5_imem.sv - instruction memory responder; optional parity via T5_IMEM_PARITY_EN
module t5_imem
  import t5_pkg::*;
#(
  parameter int    AW        = 12,
  parameter int    LAT       = 1,
  parameter string INIT_FILE = ""
) (
  input logic       sclk,
  input logic       srst,
  t5_imem_if.slave  bus
);

  if (LAT < T5_LAT_MIN || LAT > T5_LAT_MAX) begin : g_bad_lat
    $error("t5_imem: LAT out of range");
  end

  logic        iwb_bad, lwb_oor, a_re, b_en, a_perr;
  logic [31:0] a_rdata, b_rdata;
  logic        unused_sel;

  assign unused_sel = ^bus.iwb_sel;
  assign iwb_bad    = bus.iwb_wre | t5_out_of_range(bus.iwb_adr, AW);
  assign lwb_oor    = t5_out_of_range(bus.lwb_adr, AW);
  assign a_re       = bus.iwb_stb & ~iwb_bad & ~srst;
  assign b_en       = bus.lwb_stb & ~lwb_oor & ~srst;

  t5_imem_ram #(.AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
    .sclk      (sclk),
    .srst      (srst),
    .a_re_i    (a_re),
    .a_addr_i  (bus.iwb_adr[AW-1:0]),
    .a_rdata_o (a_rdata),
    .a_perr_o  (a_perr),
    .b_en_i    (b_en),
    .b_we_i    (bus.lwb_wre),
    .b_sel_i   (bus.lwb_sel),
    .b_addr_i  (bus.lwb_adr[AW-1:0]),
    .b_wdata_i (bus.lwb_dat_i),
    .b_rdata_o (b_rdata)
  );

  logic s1_v_q, s1_v_d, s1_err_q, s1_err_d;
  logic l_ack_q, l_ack_d, l_oor_q, l_oor_d;

  // Error and range flags hold between requests so the output word holds too.
  always_comb begin
    s1_v_d   = bus.iwb_stb;
    s1_err_d = s1_err_q;
    if (bus.iwb_stb) s1_err_d = iwb_bad;
    l_ack_d  = bus.lwb_stb;
    l_oor_d  = l_oor_q;
    if (bus.lwb_stb) l_oor_d = lwb_oor;
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      s1_v_q   <= 1'b0;
      s1_err_q <= 1'b0;
      l_ack_q  <= 1'b0;
      l_oor_q  <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_err_q <= s1_err_d;
      l_ack_q  <= l_ack_d;
      l_oor_q  <= l_oor_d;
    end
  end

  logic [LAT-1:0]       st_v, st_err;
  logic [LAT-1:0][31:0] st_dat;

  assign st_v[0]   = s1_v_q;
  assign st_err[0] = s1_err_q | a_perr;
  assign st_dat[0] = s1_err_q ? '0 : a_rdata;

  for (genvar k = 1; k < LAT; k++) begin : g_dly
    logic        v_q, err_q;
    logic [31:0] dat_q;
    always_ff @(posedge sclk) begin
      if (srst) begin
        v_q   <= 1'b0;
        err_q <= 1'b0;
        dat_q <= '0;
      end else begin
        v_q <= st_v[k-1];
        if (st_v[k-1]) begin
          err_q <= st_err[k-1];
          dat_q <= st_dat[k-1];
        end
      end
    end
    assign st_v[k]   = v_q;
    assign st_err[k] = err_q;
    assign st_dat[k] = dat_q;
  end

  assign bus.iwb_ack   = st_v[LAT-1] & ~st_err[LAT-1];
  assign bus.iwb_err   = st_v[LAT-1] &  st_err[LAT-1];
  assign bus.iwb_dat   = st_dat[LAT-1];
  assign bus.lwb_ack   = l_ack_q;
  assign bus.lwb_dat_o = l_oor_q ? '0 : b_rdata;

endmodule

// File: tb/tb_t5_imem.sv
// tb/tb_t5_imem.sv - table-driven and randomized bench for t5_imem (LAT=1 and LAT=3 side by side)
module tb_t5_imem;
  import t5_pkg::*;

  localparam int AW = 12;
  localparam int L0 = 1;
  localparam int L1 = 3;
`ifdef T5_IMEM_PARITY_EN
  localparam logic [1:0] PAR_EXP = 2'd2;
`else
  localparam logic [1:0] PAR_EXP = 2'd1;
`endif

  typedef struct {
    logic        rst;
    logic        fstb;
    logic        fwre;
    logic [29:0] fadr;
    logic [3:0]  fsel;
    logic [1:0]  fexp;   // 1 = ack expected, 2 = err expected
    logic [31:0] fdat;
    logic        lstb;
    logic        lwre;
    logic [29:0] ladr;
    logic [31:0] lwd;
    logic [3:0]  lsel;
    logic [31:0] ldat;
  } vec_t;

  logic sclk = 1'b0;
  logic srst;
  always #5 sclk = ~sclk;

  t5_imem_if if0();
  t5_imem_if if1();

  t5_imem #(.AW(AW), .LAT(L0)) u_dut1 (.sclk(sclk), .srst(srst), .bus(if0));
  t5_imem #(.AW(AW), .LAT(L1)) u_dut3 (.sclk(sclk), .srst(srst), .bus(if1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack1_cnt = 0;
  int ack1_first = 0;
  int lat [2] = '{L0, L1};

  logic [31:0] mdl [2**AW];
  logic        sv [2][8];
  logic        se [2][8];
  logic [31:0] sd [2][8];
  logic        lnext_v;
  logic [31:0] lnext_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++) sv[i][j] = 1'b0;
    lnext_v = 1'b0;
  endtask

  function automatic vec_t fv(input logic [29:0] a, input logic wre, input logic [1:0] fe,
                              input logic [31:0] fd);
    vec_t r = '{default: '0};
    r.fstb = 1'b1; r.fadr = a; r.fwre = wre; r.fexp = fe; r.fdat = fd; r.fsel = 4'hF;
    return r;
  endfunction

  function automatic vec_t lv(input logic [29:0] a, input logic wre, input logic [31:0] d,
                              input logic [3:0] sel, input logic [31:0] ld);
    vec_t r = '{default: '0};
    r.lstb = 1'b1; r.ladr = a; r.lwre = wre; r.lwd = d; r.lsel = sel; r.ldat = ld;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    srst = v.rst;
    if0.iwb_adr = v.fadr;  if1.iwb_adr = v.fadr;
    if0.iwb_stb = v.fstb;  if1.iwb_stb = v.fstb;
    if0.iwb_wre = v.fwre;  if1.iwb_wre = v.fwre;
    if0.iwb_sel = v.fsel;  if1.iwb_sel = v.fsel;
    if0.lwb_adr = v.ladr;  if1.lwb_adr = v.ladr;
    if0.lwb_dat_i = v.lwd; if1.lwb_dat_i = v.lwd;
    if0.lwb_sel = v.lsel;  if1.lwb_sel = v.lsel;
    if0.lwb_stb = v.lstb;  if1.lwb_stb = v.lstb;
    if0.lwb_wre = v.lwre;  if1.lwb_wre = v.lwre;
  endtask

  // Drive one cycle, predict its responses, clock, then check what is due now.
  task automatic apply(input vec_t v, input bit tbl);
    logic        bad, e;
    logic [31:0] d, old;
    int          s;
    drive(v);
    if (v.rst) begin
      clear_model();
    end else begin
      if (v.fstb) begin
        bad = v.fwre || ((v.fadr >> AW) != 0);
        e = tbl ? (v.fexp == 2'd2) : bad;
        d = tbl ? v.fdat : (bad ? 32'h0 : mdl[v.fadr[AW-1:0]]);
        for (int i = 0; i < 2; i++) begin
          s = (cyc + lat[i]) % 8;
          sv[i][s] = 1'b1; se[i][s] = e; sd[i][s] = d;
        end
      end
      lnext_v = v.lstb;
      if (v.lstb) begin
        bad = (v.ladr >> AW) != 0;
        old = bad ? 32'h0 : mdl[v.ladr[AW-1:0]];
        if (!bad && v.lwre)
          for (int b = 0; b < 4; b++)
            if (v.lsel[b]) mdl[v.ladr[AW-1:0]][b*8 +: 8] = v.lwd[b*8 +: 8];
        lnext_d = tbl ? v.ldat : old;
      end
    end
    @(posedge sclk);
    #1;
    cyc++;
    s = cyc % 8;
    for (int i = 0; i < 2; i++) begin
      logic        a, r;
      logic [31:0] od;
      if (i == 0) begin a = if0.iwb_ack; r = if0.iwb_err; od = if0.iwb_dat; end
      else        begin a = if1.iwb_ack; r = if1.iwb_err; od = if1.iwb_dat; end
      chk($sformatf("iwb_ack_lat%0d", lat[i]), 32'(a), 32'(sv[i][s] && !se[i][s]));
      chk($sformatf("iwb_err_lat%0d", lat[i]), 32'(r), 32'(sv[i][s] && se[i][s]));
      if (sv[i][s]) chk($sformatf("iwb_dat_lat%0d", lat[i]), od, sd[i][s]);
      if (i == 1 && a) begin
        if (ack1_cnt == 0) ack1_first = cyc;
        ack1_cnt++;
      end
      sv[i][s] = 1'b0;
    end
    chk("lwb_ack_lat1", 32'(if0.lwb_ack), 32'(lnext_v));
    chk("lwb_ack_lat3", 32'(if1.lwb_ack), 32'(lnext_v));
    if (lnext_v) begin
      chk("lwb_dat_lat1", if0.lwb_dat_o, lnext_d);
      chk("lwb_dat_lat3", if1.lwb_dat_o, lnext_d);
    end
    lnext_v = 1'b0;
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    vec_t tbl[$];
    int   cyc0;

    for (int i = 0; i < 2**AW; i++) mdl[i] = T5_NOP;
    clear_model();
    idle = '{default: '0};

    v = idle; v.rst = 1'b1;
    drive(v);
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_iwb_ack1", 32'(if0.iwb_ack), 0);
    chk("rst_iwb_err1", 32'(if0.iwb_err), 0);
    chk("rst_iwb_dat1", if0.iwb_dat, 0);
    chk("rst_lwb_ack1", 32'(if0.lwb_ack), 0);
    chk("rst_lwb_dat1", if0.lwb_dat_o, 0);
    chk("rst_iwb_ack3", 32'(if1.iwb_ack), 0);
    chk("rst_iwb_err3", 32'(if1.iwb_err), 0);
    chk("rst_iwb_dat3", if1.iwb_dat, 0);
    chk("rst_lwb_ack3", 32'(if1.lwb_ack), 0);
    chk("rst_lwb_dat3", if1.lwb_dat_o, 0);

    tbl.push_back(lv(30'd1, 1'b1, 32'h00100093, 4'hF, 32'h00000013));
    tbl.push_back(fv(30'd0, 1'b0, 2'd1, 32'h00000013));
    tbl.push_back(fv(30'd1, 1'b0, 2'd1, 32'h00100093));
    tbl.push_back(lv(30'd5, 1'b1, 32'h11223344, 4'hF, 32'h00000013));
    v = lv(30'd5, 1'b1, 32'hDEADBEEF, 4'b0011, 32'h11223344);
    v.fstb = 1'b1; v.fadr = 30'd5; v.fexp = 2'd1; v.fdat = 32'h11223344;
    tbl.push_back(v);
    tbl.push_back(fv(30'd5, 1'b0, 2'd1, 32'h1122BEEF));
    tbl.push_back(fv(30'h1000, 1'b0, 2'd2, 32'h0));
    tbl.push_back(fv(30'd7, 1'b1, 2'd2, 32'h0));
    tbl.push_back(lv(30'd7, 1'b0, 32'h0, 4'h0, 32'h00000013));
    tbl.push_back(lv(30'h1000, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0));
    tbl.push_back(lv(30'h1000, 1'b0, 32'h0, 4'h0, 32'h0));
    tbl.push_back(lv(30'd0, 1'b0, 32'h0, 4'h0, 32'h00000013));
    tbl.push_back(fv(30'h3FFFFFFF, 1'b0, 2'd2, 32'h0));
    tbl.push_back(lv(30'd5, 1'b0, 32'h0, 4'h0, 32'h1122BEEF));
    tbl.push_back(fv(30'd6, 1'b0, 2'd1, 32'h00000013));
    repeat (3) tbl.push_back(idle);
    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], 1'b1);

    // Eight back-to-back fetches on the LAT=3 instance: acks at +3..+10, no gaps.
    cyc0 = cyc;
    ack1_cnt = 0;
    for (int a = 0; a < 8; a++) apply(fv(30'(a), 1'b0, 2'd0, 32'h0), 1'b0);
    repeat (3) apply(idle, 1'b0);
    chk("lat3_burst_acks", 32'(ack1_cnt), 32'd8);
    chk("lat3_first_ack_offset", 32'(ack1_first - cyc0), 32'd3);

    // Reset with fetches and a load still in flight.
    for (int a = 0; a < 3; a++) begin
      v = fv(30'(a), 1'b0, 2'd0, 32'h0);
      v.lstb = 1'b1; v.ladr = 30'd1;
      apply(v, 1'b0);
    end
    v = idle; v.rst = 1'b1;
    apply(v, 1'b0);
    chk("post_rst_iwb_dat1", if0.iwb_dat, 0);
    chk("post_rst_iwb_dat3", if1.iwb_dat, 0);
    chk("post_rst_lwb_dat1", if0.lwb_dat_o, 0);
    apply(fv(30'd1, 1'b0, 2'd0, 32'h0), 1'b0);
    repeat (3) apply(idle, 1'b0);

    // Stored parity of word 2 corrupted behind the design's back.
`ifdef T5_IMEM_PARITY_EN
    u_dut1.u_ram.mem[2][8] = ~u_dut1.u_ram.mem[2][8];
    u_dut3.u_ram.mem[2][8] = ~u_dut3.u_ram.mem[2][8];
`endif
    apply(fv(30'd2, 1'b0, PAR_EXP, mdl[2]), 1'b1);
    repeat (3) apply(idle, 1'b0);
`ifdef T5_IMEM_PARITY_EN
    u_dut1.u_ram.mem[2][8] = ~u_dut1.u_ram.mem[2][8];
    u_dut3.u_ram.mem[2][8] = ~u_dut3.u_ram.mem[2][8];
`endif

    for (int n = 0; n < 600; n++) begin
      int r;
      v = idle;
      v.rst  = ($urandom_range(0, 59) == 0);
      v.fstb = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 15));
      v.fadr = (r < 13) ? 30'($urandom_range(0, 15)) : (30'h1000 + 30'($urandom_range(0, 255)));
      v.fwre = ($urandom_range(0, 15) == 0);
      v.fsel = 4'($urandom_range(0, 15));
      v.lstb = ($urandom_range(0, 1) == 1);
      v.lwre = ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 15));
      v.ladr = (r < 14) ? 30'($urandom_range(0, 15)) : (30'h1000 + 30'($urandom_range(0, 15)));
      v.lwd  = $urandom;
      v.lsel = 4'($urandom_range(0, 15));
      apply(v, 1'b0);
    end
    repeat (4) apply(idle, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
